muldiv_hilo: RTL and testbench

- Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the multi-cycle CPU.
- Executes MULT, MULTU, DIV and DIVU using one bit per cycle.
- Handshake with the control unit is start/busy/done.
- HI and LO drive dedicated inputs of the 8:1 32-bit writeback-source multiplexer, so MFHI/MFLO are plain mux selects.

---
 rtl/muldiv_hilo_pkg.sv | 27 ++
 rtl/muldiv_abs32.sv | 22 ++
 rtl/muldiv_hilo.sv | 175 +++++++++++++++++
 tb/tb_muldiv_hilo.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_hilo_pkg.sv
// Shared definitions for the multiply/divide unit and the control unit that drives it.
// - Op encodings: the operation select the control unit issues with start.
// - FSM state encoding of muldiv_hilo.
// - Small op-decoding helpers.
package muldiv_hilo_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_abs32.sv
// Combinational two's-complement conditional negate.
// Used both to take operand magnitudes and to re-apply the result sign.
// Ports:
//   val  operand
//   neg  1: res = -val, 0: res = val
//   res  result (wraps, so -0x80000000 stays 0x80000000)
module muldiv_abs32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = val;
    if (neg) begin
      res = ~val + WIDTH'(1);
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One bit per cycle: shift-add multiply, restoring divide, both on magnitudes,
// with the sign applied once at the end.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start, op      one-cycle request and operation (sampled only in IDLE)
//   a, b           rs / rt operands, sampled with start
//   mthi, mtlo     write wdata into HI / LO (IDLE only)
//   wdata          data for mthi / mtlo
//   busy           high whenever the FSM is not idle
//   done           one-cycle pulse; HI/LO already hold the new result
//   hi, lo         HI / LO registers
module muldiv_hilo
  import muldiv_hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state;
  logic [1:0]         op_q;
  logic               sa_q;
  logic               sb_q;
  logic [WIDTH-1:0]   a_q;      // original dividend, returned in HI on divide by zero
  logic [WIDTH-1:0]   opnd_q;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;    // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Operand conditioning: magnitudes only for signed ops.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_neg = op_is_signed(op) & a[WIDTH-1];
  assign b_neg = op_is_signed(op) & b[WIDTH-1];

  muldiv_abs32 #(.WIDTH(WIDTH)) u_a_abs (.val(a), .neg(a_neg), .res(a_mag));
  muldiv_abs32 #(.WIDTH(WIDTH)) u_b_abs (.val(b), .neg(b_neg), .res(b_mag));

  // Result sign correction. sa_q/sb_q are zero for unsigned ops.
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  muldiv_abs32 #(.WIDTH(WIDTH)) u_quot_fix (
    .val(acc_q[WIDTH-1:0]),
    .neg(sa_q ^ sb_q),
    .res(quot_fix)
  );
  // Remainder follows the sign of the dividend.
  muldiv_abs32 #(.WIDTH(WIDTH)) u_rem_fix (
    .val(acc_q[2*WIDTH-1:WIDTH]),
    .neg(sa_q),
    .res(rem_fix)
  );
  muldiv_abs32 #(.WIDTH(2*WIDTH)) u_prod_fix (
    .val(acc_q),
    .neg(sa_q ^ sb_q),
    .res(prod_fix)
  );

  // One iteration of the datapath.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_trial >= {1'b0, opnd_q};
    // Only used when div_ge, where the difference is below the divisor and fits WIDTH bits.
    div_diff  = div_trial[WIDTH-1:0] - opnd_q;
    div_rem   = div_ge ? div_diff : div_trial[WIDTH-1:0];

    acc_step = acc_q;
    if (op_is_div(op_q)) begin
      acc_step = {div_rem, acc_q[WIDTH-2:0], div_ge};
    end else if (acc_q[0]) begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end else begin
      acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_MULTU;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      a_q    <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mthi) hi_q <= wdata;
          if (mtlo) lo_q <= wdata;
          if (start) begin
            op_q  <= op;
            sa_q  <= a_neg;
            sb_q  <= b_neg;
            a_q   <= a;
            cnt_q <= '0;
            if (op_is_div(op)) begin
              opnd_q <= b_mag;
              acc_q  <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              opnd_q <= a_mag;
              acc_q  <= {{WIDTH{1'b0}}, b_mag};
            end
            state <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (op_is_div(op_q)) begin
            if (opnd_q == '0) begin
              hi_q <= a_q;
              lo_q <= '1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          state <= DONE;
        end
        DONE: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: the driver pushes expected HI/LO and the expected
// done edge; a monitor pops and compares whenever done is seen.
module tb_muldiv_hilo;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_hilo dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .mthi (mthi),
    .mtlo (mtlo),
    .wdata(wdata),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          start_edge;
    int          done_edge;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model straight from the arithmetic definition of each op.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      qq;
    longint      rr;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: res = {32'b0, x} * {32'b0, y};
      2'b01: res = 64'(sx * sy);
      2'b10: res = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: begin
        if (y == 0) begin
          res = {x, 32'hFFFF_FFFF};
        end else begin
          qq  = sx / sy;
          rr  = sx % sy;
          res = {rr[31:0], qq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Monitor: compares on done, checks busy while an op is outstanding, catches timeouts.
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() > 0 && cyc > q[0].done_edge) begin
        total++;
        bad++;
        $display("FAIL done_timeout: no done by edge %0d (now %0d)", q[0].done_edge, cyc);
        void'(q.pop_front());
      end else if (done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done: got done=1 want no pulse (cycle %0d)", cyc);
        end else begin
          mon_e = q.pop_front();
          chk("result_hi", hi, mon_e.hi);
          chk("result_lo", lo, mon_e.lo);
          chk("done_edge", 32'(cyc), 32'(mon_e.done_edge));
          chk("busy_at_done", {31'b0, busy}, 32'd0);
        end
      end else if (q.size() > 0 && cyc >= q[0].start_edge) begin
        chk("busy_during_op", {31'b0, busy}, 32'd1);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] expv, input bit with_mthi);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    mthi  = with_mthi;
    wdata = 32'h0000_AAAA;
    e.hi         = expv[63:32];
    e.lo         = expv[31:0];
    e.start_edge = cyc + 1;
    e.done_edge  = cyc + 35;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    if (with_mthi) chk("mthi_with_start", hi, 32'h0000_AAAA);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL wait_empty: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] s;
    case ($urandom_range(0, 9))
      0:       s = 32'h0;
      1:       s = 32'h1;
      2:       s = 32'hFFFF_FFFF;
      3:       s = 32'h8000_0000;
      4:       s = 32'($urandom_range(0, 20));
      default: s = $urandom;
    endcase
    return s;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    // Directed cases.
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    wait_empty();
    issue(2'b01, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    wait_empty();
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    wait_empty();
    issue(2'b10, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 1'b0);
    wait_empty();
    issue(2'b11, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF, 1'b0);
    wait_empty();
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
    wait_empty();

    // start and mthi while busy are both ignored.
    issue(2'b00, 32'd3, 32'd4, 64'h0000_0000_0000_000C, 1'b0);
    repeat (8) @(negedge clk);
    start = 1'b1;
    op    = 2'b10;
    a     = 32'd9;
    b     = 32'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    mthi  = 1'b1;
    wdata = 32'h0000_DEAD;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_ignored_busy", hi, 32'd0);
    wait_empty();

    // Reset mid-operation aborts.
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    wait_empty();

    // mthi/mtlo in IDLE.
    @(negedge clk);
    mthi  = 1'b1;
    wdata = 32'h0000_1234;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_idle", hi, 32'h0000_1234);
    mtlo  = 1'b1;
    wdata = 32'h0000_5678;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_idle", lo, 32'h0000_5678);
    chk("mtlo_keeps_hi", hi, 32'h0000_1234);
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'h0000_0077;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("both_hi", hi, 32'h0000_0077);
    chk("both_lo", lo, 32'h0000_0077);

    // mthi alongside start: write lands, then the result overwrites it.
    issue(2'b01, 32'hFFFF_FFFE, 32'd7, model(2'b01, 32'hFFFF_FFFE, 32'd7), 1'b1);
    wait_empty();

    // Randomized against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      issue(ro, ra, rb, model(ro, ra, rb), 1'b0);
      wait_empty();
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
